// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotating-priority search used by the FIFO write/read schedulers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    // Returns {valid, idx[2:0]}: first set bit of req searching from last+1, wrapping modulo n.
    function automatic logic [3:0] rr_next(input logic [7:0] req, input logic [2:0] last,
                                           input int unsigned n);
        logic [3:0]  res;
        int unsigned k;
        res = '0;
        for (int unsigned off = 1; off <= 8; off++) begin
            k = (32'(last) + off) % n;
            if (off <= n && !res[3] && req[k[2:0]]) begin
                res = {1'b1, k[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next requester after last_grant, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [3:0] res;

    assign res   = rr_next(8'(req), 3'(last_grant), NREQ);
    assign valid = res[3];
    assign idx   = res[IW-1:0];

endmodule

// File: rtl/fifo_wr_arb.sv
// Write-side arbiter: shares one FIFO write port among NREQ requesters with bounded bursts.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DATA_WD   = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_WD-1:0]   req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      full,
    input  logic                      near_full,
    output logic                      winc,
    output logic [DATA_WD-1:0]        wdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t      state_q;
    logic [IW-1:0]   grant_id_q;
    logic [IW-1:0]   last_grant_q;
    logic [CW-1:0]   burst_cnt_q;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            write;
    logic [CW:0]     cnt_inc;
    logic            burst_last;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    // Gated by rst_n so a write in the reset cycle is never issued.
    assign write      = rst_n && (state_q == BURST) && req[grant_id_q] && !full;
    assign cnt_inc    = {1'b0, burst_cnt_q} + (CW+1)'(1);
    assign burst_last = (cnt_inc == (CW+1)'(MAX_BURST));

    always_comb begin
        winc  = 1'b0;
        ack   = '0;
        wdata = '0;
        if (write) begin
            winc  = 1'b1;
            ack   = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_q;
            wdata = req_data[grant_id_q*DATA_WD +: DATA_WD];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IW'(NREQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req && !full && pick_valid) begin
                        grant_id_q   <= pick_idx;
                        last_grant_q <= pick_idx;
                        burst_cnt_q  <= '0;
                        state_q      <= BURST;
                    end
                end
                BURST: begin
                    if (write) begin
                        burst_cnt_q <= cnt_inc[CW-1:0];
                    end
                    if (!req[grant_id_q] || (write && (burst_last || near_full))) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q == BURST);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(winc && full));
    a_ack_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
    a_ack_winc:    assert property (@(posedge clk) disable iff (!rst_n) (|ack) |-> winc);
    a_cnt_bound:   assert property (@(posedge clk) disable iff (!rst_n)
                                    burst_cnt_q <= CW'(MAX_BURST));

endmodule
